trace_monitor: RTL and testbench
================================

TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 Parameter WIDTH, default 8: bit width of every watched channel.
REQ-002 Parameter NCH, default 5: number of watched register channels.
REQ-003 Parameter DEPTH, default 16, power of two >= 2: trace FIFO entries.
REQ-004 Parameter TICKW, default 16: tick counter and record timestamp width.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 run  in  1  level; capture allowed while high.
REQ-008 clear  in  1  synchronous pulse; restarts the trace session.
REQ-009 mode_all  in  1  1 = record every tick; 0 = record only on change.
REQ-010 step_limit  in  TICKW  tick count at which capture stops; 0 = unlimited.
REQ-011 ch_data  in  NCH*WIDTH  watched channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 out_data  in  WIDTH  output-port channel, mask bit NCH.
REQ-013 rd_valid  out  1  head record available.
REQ-014 rd_ready  in  1  consumer accepts head record.
REQ-015 rd_tick  out  TICKW  head record timestamp.
REQ-016 rd_mask  out  NCH+1  head record changed-channel mask.
REQ-017 rd_data  out  (NCH+1)*WIDTH  head record values; out_data in top WIDTH bits.
REQ-018 done  out  1  step limit reached.
REQ-019 overflow  out  1  sticky; a record was dropped.
REQ-020 drop_count  out  8  dropped records, saturating at 255.

Function
REQ-021 States: IDLE, RUN, DONE; IDLE->RUN on posedge with run=1; RUN->IDLE when run=0; RUN->DONE when tick+1 == step_limit (step_limit != 0) at a capture edge; DONE exits only via clear or reset.
REQ-022 Capture edge: posedge clk in RUN with run=1; tick increments by 1 at every capture edge, wrapping at 2^TICKW.
REQ-023 At each capture edge, channel mask bit k = (current value != snapshot k) OR snapshot invalid; snapshot then updated with current values and marked valid.
REQ-024 A record {tick before increment, mask, all current values} is pushed when mode_all=1 or mask != 0.
REQ-025 The capture edge that causes RUN->DONE also captures and pushes normally; no capture in DONE or IDLE.
REQ-026 FIFO is show-ahead: a record pushed at edge n is visible on rd_* with rd_valid=1 after edge n (zero-cycle bubble for empty FIFO).
REQ-027 Pop occurs at posedge with rd_valid=1 and rd_ready=1; rd_* are undefined-free (hold last head) but meaningless while rd_valid=0.
REQ-028 Push to a full FIFO with no simultaneous pop is dropped: overflow set, drop_count incremented (saturating); snapshot still updates.
REQ-029 Simultaneous push and pop when full: both succeed, no drop.
REQ-030 Simultaneous push and pop when empty: record passes into FIFO; rd_valid stays 1.
REQ-031 Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-032 clear has priority over capture and pop: FIFO emptied, tick=0, snapshot invalid, done=0, overflow=0, drop_count=0, state->IDLE.
REQ-033 done=1 exactly while in DONE.

Reset
REQ-034 On rst_n low, immediately and without clk: state IDLE, tick 0, snapshot invalid, FIFO empty, rd_valid 0, done 0, overflow 0, drop_count 0; rd_tick/rd_mask/rd_data 0.
REQ-035 Reset asserted mid-session discards all buffered records; first capture after release reports mask all ones.

Verification
REQ-036 Reset, run=1, mode_all=0, ch_data constant 0x0302010000 (NCH=5), out_data 0 -> one record tick 0, mask 6'b111111, then no further records.
REQ-037 Change channel 2 only at tick 5, rd_ready=1 -> second record rd_tick=5, rd_mask=6'b000100, rd_data[23:16] new value.
REQ-038 mode_all=1, step_limit=10, rd_ready=1 -> exactly 10 records ticks 0..9, done=1 after 10th capture edge, then no records.
REQ-039 DEPTH=16, mode_all=1, rd_ready=0 for 20 ticks -> 16 records retained (ticks 0..15), overflow=1, drop_count=4; draining returns ticks 0..15 in order.
REQ-040 Full FIFO with rd_ready=1 and push same edge -> no drop, count stays 16, drop_count unchanged.
REQ-041 clear pulse while in DONE with records buffered -> rd_valid=0, done=0, overflow=0 next cycle; next run capture has tick 0, mask all ones.

Source files
------------

// File: rtl/trace_monitor.sv
// Change-trace recorder: snapshots NCH channels plus out_data, queues timestamped change records.
// Show-ahead FIFO (record visible after push edge); push to full FIFO without a pop is dropped.
module trace_monitor #(
   parameter int WIDTH = 8,
   parameter int NCH   = 5,
   parameter int DEPTH = 16,
   parameter int TICKW = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       run,
   input  logic                       clear,
   input  logic                       mode_all,
   input  logic [TICKW-1:0]           step_limit,
   input  logic [NCH*WIDTH-1:0]       ch_data,
   input  logic [WIDTH-1:0]           out_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [TICKW-1:0]           rd_tick,
   output logic [NCH:0]               rd_mask,
   output logic [(NCH+1)*WIDTH-1:0]   rd_data,
   output logic                       done,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = (NCH + 1) * WIDTH;
   localparam int RW = TICKW + NCH + 1 + DW;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [TICKW-1:0] tick, tick_inc;
   logic [DW-1:0]    snap, cur;
   logic             snap_vld;
   logic [NCH:0]     mask;
   logic [RW-1:0]    mem [DEPTH];
   logic [RW-1:0]    last_rec, head_rec, new_rec;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             capture, push_req, push, pop, drop, full, empty;

   assign cur      = {out_data, ch_data};
   assign tick_inc = tick + TICKW'(1);
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_rec = mem[rd_ptr[AW-1:0]];
   assign new_rec  = {tick, mask, cur};

   always_comb begin
      mask = '0;
      for (int k = 0; k <= NCH; k++) begin
         mask[k] = !snap_vld || (cur[k*WIDTH +: WIDTH] != snap[k*WIDTH +: WIDTH]);
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (run) state_nxt = RUN;
            RUN: begin
               if (!run) begin
                  state_nxt = IDLE;
               end else begin
                  capture = 1'b1;
                  if (step_limit != '0 && tick_inc == step_limit) state_nxt = DONE;
               end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
   assign push_req = capture && (mode_all || mask != '0);
   assign pop      = rd_valid && rd_ready && !clear;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tick       <= '0;
         snap       <= '0;
         snap_vld   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         last_rec   <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         state <= state_nxt;
         if (clear) begin
            tick       <= '0;
            snap_vld   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
         end else begin
            if (capture) begin
               tick     <= tick_inc;
               snap     <= cur;
               snap_vld <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
               rd_ptr   <= rd_ptr + (AW+1)'(1);
               last_rec <= head_rec;
            end
            if (drop) begin
               overflow <= 1'b1;
               if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= new_rec;
   end

   // With the FIFO empty the outputs keep showing the most recently consumed record.
   assign rd_valid = !empty;
   assign {rd_tick, rd_mask, rd_data} = empty ? last_rec : head_rec;
   assign done = (state == DONE);

endmodule

// File: tb/tb_trace_monitor.sv
// Randomized and directed bench for trace_monitor against a queue-based reference model.
module tb_trace_monitor;

   localparam int WIDTH = 8;
   localparam int NCH   = 5;
   localparam int DEPTH = 16;
   localparam int TICKW = 16;
   localparam int DW    = (NCH + 1) * WIDTH;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 run, clear, mode_all, rd_ready;
   logic [TICKW-1:0]     step_limit;
   logic [NCH*WIDTH-1:0] ch_data;
   logic [WIDTH-1:0]     out_data;
   logic                 rd_valid, done, overflow;
   logic [TICKW-1:0]     rd_tick;
   logic [NCH:0]         rd_mask;
   logic [DW-1:0]        rd_data;
   logic [7:0]           drop_count;

   trace_monitor #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TICKW(TICKW)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .mode_all(mode_all),
      .step_limit(step_limit), .ch_data(ch_data), .out_data(out_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_tick(rd_tick), .rd_mask(rd_mask),
      .rd_data(rd_data), .done(done), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [TICKW-1:0] t;
      logic [NCH:0]     m;
      logic [DW-1:0]    d;
   } rec_t;

   rec_t             q[$];
   rec_t             last_head;
   bit               m_on, m_fin, m_snap_ok, m_ovf;
   int               m_tick, m_drops;
   logic [DW-1:0]    m_snap;
   logic [TICKW-1:0] pops[$];
   int               n_pass = 0;
   int               n_total = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      q.delete();
      last_head = '0;
      m_on = 0; m_fin = 0; m_snap_ok = 0; m_ovf = 0;
      m_tick = 0; m_drops = 0; m_snap = '0;
   endtask

   // Abstract session model: a trace session is either stopped, running or finished.
   task automatic model_step();
      logic [DW-1:0] cur;
      logic [NCH:0]  m;
      rec_t          r;
      cur = {out_data, ch_data};
      if (clear) begin
         q.delete();
         m_tick = 0; m_snap_ok = 0; m_on = 0; m_fin = 0; m_ovf = 0; m_drops = 0;
         return;
      end
      if (q.size() > 0 && rd_ready) last_head = q.pop_front();
      if (m_fin) begin
      end else if (!m_on) begin
         m_on = run;
      end else if (!run) begin
         m_on = 0;
      end else begin
         for (int k = 0; k <= NCH; k++)
            m[k] = !m_snap_ok || (cur[k*WIDTH +: WIDTH] != m_snap[k*WIDTH +: WIDTH]);
         if (mode_all || m != 0) begin
            if (q.size() >= DEPTH) begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end else begin
               r.t = TICKW'(m_tick); r.m = m; r.d = cur;
               q.push_back(r);
            end
         end
         m_snap = cur; m_snap_ok = 1;
         m_tick = (m_tick + 1) % (1 << TICKW);
         if (step_limit != 0 && m_tick == int'(step_limit)) m_fin = 1;
      end
   endtask

   task automatic compare();
      rec_t e;
      e = (q.size() > 0) ? q[0] : last_head;
      check("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
      check("rd_tick", 64'(rd_tick), 64'(e.t));
      check("rd_mask", 64'(rd_mask), 64'(e.m));
      check("rd_data", 64'(rd_data), 64'(e.d));
      check("done", 64'(done), 64'(m_fin));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_count", 64'(drop_count), 64'(m_drops));
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         if (rd_valid && rd_ready && !clear) pops.push_back(rd_tick);
         model_step();
         @(posedge clk);
         #1;
         compare();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_tick", 64'(rd_tick), 64'd0);
      check("rst_mask", 64'(rd_mask), 64'd0);
      check("rst_data", 64'(rd_data), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_drops", 64'(drop_count), 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; run = 0; clear = 0; mode_all = 0; rd_ready = 0;
      step_limit = '0; ch_data = '0; out_data = '0;
      #2;
      do_reset();

      // single record for constant inputs, then a change on channel 2 at tick 5
      run = 1; ch_data = 40'h0302010000;
      cyc(4);
      check("const_valid", 64'(rd_valid), 64'd1);
      check("const_tick", 64'(rd_tick), 64'd0);
      check("const_mask", 64'(rd_mask), 64'h3F);
      rd_ready = 1;
      cyc(2);
      check("const_no_more", 64'(rd_valid), 64'd0);
      ch_data[23:16] = 8'h77;
      cyc(1);
      check("chg_tick", 64'(rd_tick), 64'd5);
      check("chg_mask", 64'(rd_mask), 64'b000100);
      check("chg_val", 64'(rd_data[23:16]), 64'h77);
      cyc(2);

      // step limit of 10
      pulse_clear();
      pops.delete();
      mode_all = 1; step_limit = 16'd10;
      cyc(16);
      check("sl_count", 64'(pops.size()), 64'd10);
      if (pops.size() > 0) check("sl_last", 64'(pops[pops.size()-1]), 64'd9);
      check("sl_done", 64'(done), 64'd1);

      // overflow: 20 captures into 16 entries, then drain in order
      pulse_clear();
      step_limit = '0; rd_ready = 0;
      cyc(21);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_drops", 64'(drop_count), 64'd4);
      run = 0;
      cyc(1);
      pops.delete();
      rd_ready = 1;
      cyc(18);
      check("drain_n", 64'(pops.size()), 64'd16);
      for (int i = 0; i < 16 && i < pops.size(); i++) check("drain_tick", 64'(pops[i]), 64'(i));

      // push and pop together on a full FIFO
      pulse_clear();
      run = 1; rd_ready = 0;
      cyc(17);
      rd_ready = 1;
      cyc(1);
      check("full_pp_drops", 64'(drop_count), 64'd0);
      run = 0; rd_ready = 0;
      cyc(1);
      pops.delete();
      rd_ready = 1;
      cyc(20);
      check("full_pp_count", 64'(pops.size()), 64'd16);

      // clear while finished with buffered records
      pulse_clear();
      run = 1; rd_ready = 0; step_limit = 16'd20;
      cyc(23);
      check("pre_clr_done", 64'(done), 64'd1);
      check("pre_clr_ovf", 64'(overflow), 64'd1);
      pulse_clear();
      check("clr_valid", 64'(rd_valid), 64'd0);
      check("clr_done", 64'(done), 64'd0);
      check("clr_ovf", 64'(overflow), 64'd0);
      cyc(2);
      check("clr_first_tick", 64'(rd_tick), 64'd0);
      check("clr_first_mask", 64'(rd_mask), 64'h3F);

      // reset mid-session
      step_limit = '0; mode_all = 0;
      cyc(5);
      do_reset();
      cyc(2);
      check("rst_first_mask", 64'(rd_mask), 64'h3F);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         run   = ($urandom_range(0, 19) != 0);
         clear = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 63) == 0) mode_all = ~mode_all;
         if ($urandom_range(0, 99) == 0)
            step_limit = ($urandom_range(0, 1) != 0) ? '0 : TICKW'($urandom_range(1, 40));
         rd_ready = ((n / 60) % 3 == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NCH; k++)
            if ($urandom_range(0, 7) == 0) ch_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
         if ($urandom_range(0, 7) == 0) out_data = WIDTH'($urandom);
         if (n == 1500) begin
            do_reset();
            clear = 1'b0;
         end
         cyc(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
